// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, per-letter symbol table, FSM states and run lengths.
// The symbol table is the one the encoder also uses, so both ends agree on the alphabet.
package morse_pkg;

    localparam logic [2:0] LETTER_A = 3'd0;
    localparam logic [2:0] LETTER_B = 3'd1;
    localparam logic [2:0] LETTER_C = 3'd2;
    localparam logic [2:0] LETTER_D = 3'd3;
    localparam logic [2:0] LETTER_E = 3'd4;
    localparam logic [2:0] LETTER_F = 3'd5;
    localparam logic [2:0] LETTER_G = 3'd6;
    localparam logic [2:0] LETTER_H = 3'd7;

    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;
    localparam int GAP_UNITS  = 3;
    localparam int MAX_SYMS   = 4;
    localparam int MARK_SAT   = 4;

    // Patterns are right-aligned, 1 = dash, first-sent symbol in the highest used bit.
    localparam logic [3:0] LETTER_SYM [8] = '{
        4'b0001, 4'b1000, 4'b1010, 4'b0100,
        4'b0000, 4'b0010, 4'b0110, 4'b0000
    };
    localparam logic [2:0] LETTER_LEN [8] = '{
        3'd2, 3'd4, 3'd4, 3'd3,
        3'd1, 3'd4, 3'd3, 3'd4
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_ERRWAIT
    } morse_state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] letter;
    } morse_match_t;

    function automatic morse_match_t match_symbols(input logic [2:0] nsym,
                                                   input logic [3:0] sym);
        morse_match_t m;
        logic [3:0]   mask;
        m    = '0;
        mask = 4'((5'd1 << nsym) - 5'd1);
        for (int i = 0; i < 8; i++) begin
            if (!m.hit && nsym == LETTER_LEN[i] && (sym & mask) == LETTER_SYM[i]) begin
                m.hit    = 1'b1;
                m.letter = 3'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Serial line and decoded-letter bundle between the Morse receiver and its user.
interface morse_decoder_if;

    logic       DotDashIn;
    logic [2:0] Letter;
    logic       Valid;
    logic       Error;

    modport master (
        output DotDashIn,
        input  Letter,
        input  Valid,
        input  Error
    );

    modport slave (
        input  DotDashIn,
        output Letter,
        output Valid,
        output Error
    );

endinterface

// File: rtl/morse_unit_tick.sv
// Morse unit timebase: one-cycle Tick every UNIT_DIV clocks, first Tick UNIT_DIV cycles after Reset.
module morse_unit_tick #(
    parameter int UNIT_DIV = 250
) (
    input  logic ClockIn,
    input  logic Reset,
    output logic Tick
);

    localparam logic [7:0] RELOAD = 8'(UNIT_DIV - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = (count_q == 8'd0) ? RELOAD : count_q - 8'd1;
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign Tick = (count_q == 8'd0);

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: samples the line once per unit and decodes letters A-H to a 3-bit code.
// Define MORSE_DECODER_SYNC_EN to insert a 2-flop synchroniser on DotDashIn for asynchronous input.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_DIV = 250
) (
    input  logic            ClockIn,
    input  logic            Reset,
    morse_decoder_if.slave  bus
);

    logic          tick;
    logic          sample;
    morse_state_e  state_q, state_d;
    logic [3:0]    sym_q, sym_d;
    logic [2:0]    nsym_q, nsym_d;
    logic [2:0]    mark_q, mark_d;
    logic [1:0]    space_q, space_d;
    logic [2:0]    letter_q, letter_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    morse_match_t  match;

    morse_unit_tick #(.UNIT_DIV(UNIT_DIV)) u_tick (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .Tick    (tick)
    );

`ifdef MORSE_DECODER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.DotDashIn;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = bus.DotDashIn;
`endif

    assign match = match_symbols(nsym_q, sym_q);

    // space_q counts sampled space units; reaching GAP_UNITS closes the letter or ends error recovery.
    always_comb begin
        state_d  = state_q;
        sym_d    = sym_q;
        nsym_d   = nsym_q;
        mark_d   = mark_q;
        space_d  = space_q;
        letter_d = letter_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    sym_d  = '0;
                    nsym_d = '0;
                    if (sample) begin
                        state_d = ST_MARK;
                        mark_d  = 3'd1;
                    end
                end
                ST_MARK: begin
                    if (sample) begin
                        if (mark_q != 3'(MARK_SAT)) begin
                            mark_d = mark_q + 3'd1;
                        end
                    end else if ((mark_q == 3'(DOT_UNITS) || mark_q == 3'(DASH_UNITS)) &&
                                 nsym_q != 3'(MAX_SYMS)) begin
                        sym_d   = {sym_q[2:0], mark_q == 3'(DASH_UNITS)};
                        nsym_d  = nsym_q + 3'd1;
                        state_d = ST_SPACE;
                        space_d = 2'd1;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_ERRWAIT;
                        space_d = 2'd1;
                    end
                end
                ST_SPACE: begin
                    if (!sample) begin
                        if (space_q == 2'(GAP_UNITS - 1)) begin
                            if (match.hit) begin
                                letter_d = match.letter;
                                valid_d  = 1'b1;
                            end else begin
                                error_d = 1'b1;
                            end
                            state_d = ST_IDLE;
                            sym_d   = '0;
                            nsym_d  = '0;
                        end else begin
                            space_d = space_q + 2'd1;
                        end
                    end else if (space_q == 2'd1) begin
                        state_d = ST_MARK;
                        mark_d  = 3'd1;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_ERRWAIT;
                        space_d = 2'd0;
                    end
                end
                ST_ERRWAIT: begin
                    if (!sample) begin
                        if (space_q == 2'(GAP_UNITS - 1)) begin
                            state_d = ST_IDLE;
                            sym_d   = '0;
                            nsym_d  = '0;
                        end else begin
                            space_d = space_q + 2'd1;
                        end
                    end else begin
                        space_d = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            sym_q    <= '0;
            nsym_q   <= '0;
            mark_q   <= '0;
            space_q  <= '0;
            letter_q <= LETTER_A;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sym_q    <= sym_d;
            nsym_q   <= nsym_d;
            mark_q   <= mark_d;
            space_q  <= space_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign bus.Letter = letter_q;
    assign bus.Valid  = valid_q;
    assign bus.Error  = error_q;

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Serial Morse receiver for the lab Morse datapath. Samples the DotDashIn line once per Morse unit, measures mark/space run lengths, assembles dot/dash symbols, and decodes letters A–H back to the 3-bit Letter code the encoder accepts. Used for loopback checking of the encoder and as the receive end of the board-to-board Morse link.

## Interface
- UNIT_DIV, 250: ClockIn cycles per Morse unit; legal range 2–255.
- ClockIn  input  1  system clock.
- Reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- DotDashIn  input  1  serial Morse line; 1 = mark (light on), 0 = space.
- Letter  output  3  last decoded letter: 000 A, 001 B, 010 C, 011 D, 100 E, 101 F, 110 G, 111 H; reset 000; holds until next valid decode.
- Valid  output  1  one-ClockIn-cycle pulse when Letter is updated; reset 0.
- Error  output  1  one-ClockIn-cycle pulse on malformed input; reset 0.

## Operation
- Unit tick: down-counter reset to UNIT_DIV-1, decrements each ClockIn, tick when 0, reloads UNIT_DIV-1. Tick period exactly UNIT_DIV cycles. All FSM activity happens only on tick cycles.
- Line encoding: dot = 1 mark unit, dash = 3 mark units, intra-letter gap = 1 space unit, letter end = 3 or more space units.
- Symbol store: sym[3:0] left-shifted, sym <= {sym[2:0], is_dash}; nsym counts 0–4. Match on (nsym, sym[nsym-1:0]): A 2/01, B 4/1000, C 4/1010, D 3/100, E 1/0, F 4/0010, G 3/110, H 4/0000.
- Mark counter saturates at 4; space counter saturates at 3.
- States:
  - IDLE: sym, nsym cleared. Tick with sample 1 -> MARK, mark=1.
  - MARK: tick with 1 -> mark+1. Tick with 0: mark 1 -> dot, 3 -> dash, append, -> SPACE, space=1. Mark 2 or >=4 -> Error, -> ERRWAIT. Append while nsym==4 -> Error, -> ERRWAIT.
  - SPACE: tick with 0 -> space+1. When space reaches 3: pattern match -> Letter, Valid; no match -> Error; then -> IDLE. Tick with 1: space 1 -> MARK, mark=1. Space 2 -> Error, -> ERRWAIT.
  - ERRWAIT: counts consecutive space ticks; any mark resets the count; 3 spaces -> IDLE. No further Error pulses in this state.
- Valid and Error are never asserted in the same cycle.
- Reset mid-letter discards partial symbols with no Valid or Error. First tick is UNIT_DIV cycles after Reset falls.

## Timing
- FSM, Letter, Valid, and Error are registered on the ClockIn edge that ends the tick cycle. Valid/Error are high for the following single cycle.
- Decode latency: Valid asserts 1 cycle after the tick that samples the third consecutive space unit (plus synchroniser delay, see Configuration).
- Back-to-back letters separated by exactly 3 space units decode correctly. The next mark may arrive on the tick immediately after the decode tick.
- Sample alignment: DotDashIn must be stable for a full unit; the receiver does not phase-lock to the transmitter.

## Configuration
- MORSE_DECODER_SYNC_EN defined: DotDashIn passes through a 2-flop synchroniser before sampling, for off-board or asynchronous input. All input-to-output latencies grow by 2 ClockIn cycles. Synchroniser flops reset to 0.
- Not defined: DotDashIn is sampled directly. Used for same-clock loopback with the encoder.

## Structure
- Shared package morse_pkg:
  - Letter code constants LETTER_A..LETTER_H.
  - Per-letter symbol patterns and lengths. This single table is shared with the encoder.
  - FSM state enum.
  - Run-length constants DOT_UNITS=1, DASH_UNITS=3, GAP_UNITS=3.
- Sub-module morse_unit_tick: parameter UNIT_DIV, ports ClockIn, Reset, Tick. Same counter also reusable by the encoder.

## Test plan
- UNIT_DIV=4, line units 1,0,1,1,1,0,0,0 ("A") -> Valid 1 cycle with Letter=000, Error stays 0.
- Units 1,0,1,0,1,0,1,0,0,0 ("H") then immediately 1,0,0,0 ("E") -> Letter=111 then 100, two Valid pulses 16 cycles apart.
- Line held at 1 for 6 units -> exactly one Error pulse. No Valid until 3 spaces then a correct "E" is received.
- Five dots 1,0 ×5 -> Error on the fifth mark's end; Letter unchanged.
- Units 1,0,0,1,0,0,0 (2-unit gap) -> Error; the following "A" decodes as 000.
- Reset asserted mid-"C" after two symbols -> Letter=000, Valid/Error 0 immediately. A subsequent full "C" -> Letter=010.
